mod_layer_sequencer: RTL

//  Sequences one neuron-layer dot product over the shared cache. Takes the

---
 rtl/mod_layer_sequencer.sv | 205 ++++++++++++++++++++
 1 files changed

// File: rtl/mod_layer_sequencer.sv
// -----------------------------------------------------------------------------
// mod_layer_sequencer
// Sequences one neuron-layer dot product over a shared single-port cache.
// For each of numOps terms it reads an index, then the activation at
// offset+index, then the weight at weightOffset+cnt, and multiply-accumulates
// in fixed point. The saturated result word is written to dest, and opDone
// pulses for one cycle.
// While busy the sequencer owns the cache port, holds critical high, and drops
// any host write (hostStall).
// Optional build macro: LAYER_SEQ_RELU_EN. When it is defined, a negative
// saturated result is stored as zero.
// -----------------------------------------------------------------------------
module mod_layer_sequencer #(
    parameter int DATA_W    = 16,
    parameter int ACC_W     = 40,
    parameter int FRAC_BITS = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              beginOp,
    input  logic [15:0]       offsetReg,
    input  logic [15:0]       destReg,
    input  logic [15:0]       numOpsReg,
    input  logic [15:0]       indexOffsetReg,
    input  logic [15:0]       weightOffsetReg,
    input  logic              hostWE,
    input  logic [15:0]       hostAddr,
    input  logic [DATA_W-1:0] hostDataIn,
    input  logic [DATA_W-1:0] cacheDataOut,
    output logic [15:0]       cacheAddrIn,
    output logic [DATA_W-1:0] cacheDataIn,
    output logic              cacheWE,
    output logic              critical,
    output logic              readyForNextOp,
    output logic              opDone,
    output logic              hostStall
);

    // Top bit of the result slice taken from the accumulator
    localparam int HI = FRAC_BITS + DATA_W - 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_RD_IDX,
        S_RD_ACT,
        S_RD_W,
        S_MAC,
        S_WRITE,
        S_DONE
    } state_t;

    state_t                    r_state;
    state_t                    w_state_next;

    // Operand latches, held for the whole operation
    logic [15:0]               r_offset;
    logic [15:0]               r_dest;
    logic [15:0]               r_num_ops;
    logic [15:0]               r_idx_off;
    logic [15:0]               r_w_off;

    logic [15:0]               r_cnt;
    logic signed [DATA_W-1:0]  r_act;
    logic signed [ACC_W-1:0]   r_acc;

    logic [15:0]               w_idx_addr;
    logic [15:0]               w_act_addr;
    logic [15:0]               w_w_addr;
    logic                      w_last_term;
    logic signed [2*DATA_W-1:0] w_product;
    logic signed [ACC_W-1:0]   w_acc_next;
    logic [ACC_W-1-HI:0]       w_upper;
    logic                      w_in_range;
    logic [DATA_W-1:0]         w_sat;
    logic [DATA_W-1:0]         w_result;

    // Address generation; every sum wraps modulo 2^16
    assign w_idx_addr  = r_offset + r_idx_off + r_cnt;
    assign w_act_addr  = r_offset + cacheDataOut;   // index arrives on the read bus this cycle
    assign w_w_addr    = r_w_off + r_cnt;
    assign w_last_term = (r_cnt == r_num_ops - 16'd1);

    // Signed MAC; the accumulator wraps at ACC_W and is never clamped
    assign w_product  = r_act * $signed(cacheDataOut);
    assign w_acc_next = r_acc + {{(ACC_W-2*DATA_W){w_product[2*DATA_W-1]}}, w_product};

    // The slice is valid only when every bit above it matches its sign bit
    assign w_upper    = r_acc[ACC_W-1:HI];
    assign w_in_range = (&w_upper) | ~(|w_upper);
    assign w_sat      = w_in_range       ? r_acc[HI:FRAC_BITS] :
                        r_acc[ACC_W-1]   ? {1'b1, {(DATA_W-1){1'b0}}} :
                                           {1'b0, {(DATA_W-1){1'b1}}};

`ifdef LAYER_SEQ_RELU_EN
    assign w_result = w_sat[DATA_W-1] ? '0 : w_sat;
`else
    assign w_result = w_sat;
`endif

    assign hostStall = hostWE & critical;

    // State register
    always_ff @(posedge clk) begin
        // NOTE: clocked state uses non-blocking assignments so every register
        // samples the pre-edge values, independent of process ordering.
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state logic and cache-port mux
    always_comb begin
        // NOTE: every output gets a default before the case, so no path
        // leaves a signal unassigned and no latch is inferred.
        w_state_next   = r_state;
        cacheAddrIn    = '0;
        cacheDataIn    = '0;
        cacheWE        = 1'b0;
        critical       = 1'b1;
        readyForNextOp = 1'b0;
        opDone         = 1'b0;
        unique case (r_state)
            S_IDLE: begin
                critical       = 1'b0;
                readyForNextOp = 1'b1;
                cacheAddrIn    = hostAddr;
                cacheDataIn    = hostDataIn;
                cacheWE        = hostWE;
                if (beginOp) begin
                    w_state_next = (numOpsReg == 16'd0) ? S_DONE : S_RD_IDX;
                end
            end
            S_RD_IDX: begin
                cacheAddrIn  = w_idx_addr;
                w_state_next = S_RD_ACT;
            end
            S_RD_ACT: begin
                cacheAddrIn  = w_act_addr;
                w_state_next = S_RD_W;
            end
            S_RD_W: begin
                cacheAddrIn  = w_w_addr;
                w_state_next = S_MAC;
            end
            S_MAC: begin
                w_state_next = w_last_term ? S_WRITE : S_RD_IDX;
            end
            S_WRITE: begin
                cacheWE      = 1'b1;
                cacheAddrIn  = r_dest;
                cacheDataIn  = w_result;
                w_state_next = S_DONE;
            end
            S_DONE: begin
                opDone       = 1'b1;
                w_state_next = S_IDLE;
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    // Operand latches, term counter, activation capture and accumulator
    always_ff @(posedge clk) begin
        if (rst) begin
            r_offset  <= '0;
            r_dest    <= '0;
            r_num_ops <= '0;
            r_idx_off <= '0;
            r_w_off   <= '0;
            r_cnt     <= '0;
            r_act     <= '0;
            r_acc     <= '0;
        end else begin
            unique case (r_state)
                S_IDLE: begin
                    if (beginOp) begin
                        r_offset  <= offsetReg;
                        r_dest    <= destReg;
                        r_num_ops <= numOpsReg;
                        r_idx_off <= indexOffsetReg;
                        r_w_off   <= weightOffsetReg;
                        r_cnt     <= '0;
                        r_acc     <= '0;
                    end
                end
                S_RD_W: begin
                    r_act <= $signed(cacheDataOut);
                end
                S_MAC: begin
                    r_acc <= w_acc_next;
                    if (!w_last_term) begin
                        r_cnt <= r_cnt + 16'd1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule
